// File: rtl/audio_tick_gen.sv
// Audio-sample tick generator: int+frac divisor, runtime-reloadable, with per-channel service strobes.
// Latency: tick is registered one cycle after the period boundary; the strobe for slot 0 is coincident with the tick.
// Backpressure: IO_cfg_ready drops while a divisor is pending and returns the cycle after it is applied at a boundary.
// Optional: define AUDIO_TICK_COUNT_EN to add the 32-bit IO_tick_count output.
module audio_tick_gen #(
  parameter int INT_W        = 12,
  parameter int FRAC_W       = 8,
  parameter int DEFAULT_INT  = 1507,
  parameter int DEFAULT_FRAC = 0,
  parameter int NUM_CHAN     = 8,
  parameter int SLOT_CYCLES  = 16
) (
  input  logic                                           IO_main_clk,
  input  logic                                           IO_rst_n,
  input  logic                                           IO_enable,
  input  logic                                           IO_cfg_valid,
  input  logic [INT_W-1:0]                               IO_cfg_int,
  input  logic [FRAC_W-1:0]                              IO_cfg_frac,
  output logic                                           IO_cfg_ready,
  output logic                                           IO_audio_tick,
  output logic                                           IO_chan_strobe,
  output logic [((NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1)-1:0] IO_chan_idx,
  output logic                                           IO_overrun,
  input  logic                                           IO_overrun_clr
`ifdef AUDIO_TICK_COUNT_EN
  ,
  output logic [31:0]                                    IO_tick_count
`endif
);

  localparam int IDX_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CHAN - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOT_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } seq_state_t;

  // ---------------------------------------------------------------------------
  // Divider state
  // ---------------------------------------------------------------------------
  // Counter is one bit wider than the divisor so that active_int+1 (a carried
  // period end) is always representable.
  logic [INT_W:0]      cnt_q, cnt_d;
  logic [FRAC_W-1:0]   acc_q, acc_d;
  logic                carry_q, carry_d;
  logic [INT_W-1:0]    act_int_q, act_int_d;
  logic [FRAC_W-1:0]   act_frac_q, act_frac_d;
  logic [INT_W-1:0]    pend_int_q, pend_int_d;
  logic [FRAC_W-1:0]   pend_frac_q, pend_frac_d;
  logic                pend_vld_q, pend_vld_d;
  logic                audio_tick_q, audio_tick_d;

  logic [INT_W:0]      end_val;
  logic [FRAC_W:0]     acc_sum;
  logic                boundary;
  logic                cfg_accept;

  // Sequencer state
  seq_state_t          state_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [IDX_W-1:0]    idx_q;
  logic                strobe_q;
  logic                overrun_q;

  // Period end stretches by one cycle whenever the previous fractional add carried.
  assign end_val    = {1'b0, act_int_q} + {{INT_W{1'b0}}, carry_q};
  assign acc_sum    = {1'b0, acc_q} + {1'b0, act_frac_q};
  assign boundary   = IO_enable && (cnt_q == end_val);
  assign cfg_accept = IO_cfg_valid && !pend_vld_q;

  // Next-state for the divider, accumulator and divisor reload path.
  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    carry_d      = carry_q;
    act_int_d    = act_int_q;
    act_frac_d   = act_frac_q;
    pend_int_d   = pend_int_q;
    pend_frac_d  = pend_frac_q;
    pend_vld_d   = pend_vld_q;
    audio_tick_d = 1'b0;

    if (boundary) begin
      cnt_d        = '0;
      audio_tick_d = 1'b1;
      if (pend_vld_q) begin
        // A new divisor starts from a clean fractional phase.
        act_int_d  = pend_int_q;
        act_frac_d = pend_frac_q;
        acc_d      = '0;
        carry_d    = 1'b0;
        pend_vld_d = 1'b0;
      end else begin
        acc_d   = acc_sum[FRAC_W-1:0];
        carry_d = acc_sum[FRAC_W];
      end
    end else if (IO_enable) begin
      cnt_d = cnt_q + {{INT_W{1'b0}}, 1'b1};
    end

    // An offer taken on a boundary cycle only lands in the pending register,
    // so it is applied at the following boundary.
    if (cfg_accept) begin
      pend_int_d  = IO_cfg_int;
      pend_frac_d = IO_cfg_frac;
      pend_vld_d  = 1'b1;
    end
  end

  // Divider registers with synchronous active-low reset.
  always_ff @(posedge IO_main_clk) begin
    if (!IO_rst_n) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      carry_q      <= 1'b0;
      act_int_q    <= INT_W'(DEFAULT_INT);
      act_frac_q   <= FRAC_W'(DEFAULT_FRAC);
      pend_int_q   <= '0;
      pend_frac_q  <= '0;
      pend_vld_q   <= 1'b0;
      audio_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      carry_q      <= carry_d;
      act_int_q    <= act_int_d;
      act_frac_q   <= act_frac_d;
      pend_int_q   <= pend_int_d;
      pend_frac_q  <= pend_frac_d;
      pend_vld_q   <= pend_vld_d;
      audio_tick_q <= audio_tick_d;
    end
  end

  // Slot sequencer: strobes channels 0..NUM_CHAN-1 SLOT_CYCLES apart after each
  // tick; it ignores IO_enable so a running sequence always completes.
  always_ff @(posedge IO_main_clk) begin
    if (!IO_rst_n) begin
      state_q   <= S_IDLE;
      slot_q    <= '0;
      idx_q     <= '0;
      strobe_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;

      // Clear first so that a simultaneous set below wins.
      if (IO_overrun_clr) begin
        overrun_q <= 1'b0;
      end

      if (boundary) begin
        if (state_q == S_RUN) begin
          overrun_q <= 1'b1;
        end
        strobe_q <= 1'b1;
        idx_q    <= '0;
        slot_q   <= '0;
        state_q  <= (NUM_CHAN == 1) ? S_IDLE : S_RUN;
      end else if (state_q == S_RUN) begin
        if (slot_q == LAST_SLOT) begin
          slot_q   <= '0;
          strobe_q <= 1'b1;
          idx_q    <= idx_q + IDX_W'(1);
          if ((idx_q + IDX_W'(1)) == LAST_IDX) begin
            state_q <= S_IDLE;
          end
        end else begin
          slot_q <= slot_q + SLOT_W'(1);
        end
      end
    end
  end

`ifdef AUDIO_TICK_COUNT_EN
  logic [31:0] tick_count_q;

  // Running tick count, advanced on the edge that raises IO_audio_tick.
  always_ff @(posedge IO_main_clk) begin
    if (!IO_rst_n) begin
      tick_count_q <= '0;
    end else if (boundary) begin
      tick_count_q <= tick_count_q + 32'd1;
    end
  end

  assign IO_tick_count = tick_count_q;
`endif

  assign IO_cfg_ready   = !pend_vld_q;
  assign IO_audio_tick  = audio_tick_q;
  assign IO_chan_strobe = strobe_q;
  assign IO_chan_idx    = idx_q;
  assign IO_overrun     = overrun_q;

endmodule

// File: tb/tb_audio_tick_gen.sv
// Self-checking bench for audio_tick_gen: scoreboard of expected tick and strobe cycles.
// Cycle 0 is the last clock edge that samples reset low; cycles count edges from there.
// Outputs are sampled on the falling edge by the monitor and #1 after the rising edge by the stimulus.
module tb_audio_tick_gen;

  localparam int INT_W       = 12;
  localparam int FRAC_W      = 8;
  localparam int NUM_CHAN    = 4;
  localparam int SLOT_CYCLES = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              cfg_valid;
  logic [INT_W-1:0]  cfg_int;
  logic [FRAC_W-1:0] cfg_frac;
  logic              cfg_ready;
  logic              tick;
  logic              strobe;
  logic [1:0]        idx;
  logic              overrun;
  logic              ovr_clr;
`ifdef AUDIO_TICK_COUNT_EN
  logic [31:0]       tick_count;
`endif

  typedef struct {
    int c;
    int idx;
  } strb_t;

  int    exp_ticks[$];
  strb_t exp_strbs[$];
  int    cyc;
  bit    mon_en;
  int    n_tests;
  int    n_fail;
  int    exp_cnt;

  audio_tick_gen #(
    .INT_W        (INT_W),
    .FRAC_W       (FRAC_W),
    .DEFAULT_INT  (9),
    .DEFAULT_FRAC (0),
    .NUM_CHAN     (NUM_CHAN),
    .SLOT_CYCLES  (SLOT_CYCLES)
  ) dut (
    .IO_main_clk    (clk),
    .IO_rst_n       (rst_n),
    .IO_enable      (en),
    .IO_cfg_valid   (cfg_valid),
    .IO_cfg_int     (cfg_int),
    .IO_cfg_frac    (cfg_frac),
    .IO_cfg_ready   (cfg_ready),
    .IO_audio_tick  (tick),
    .IO_chan_strobe (strobe),
    .IO_chan_idx    (idx),
    .IO_overrun     (overrun),
    .IO_overrun_clr (ovr_clr)
`ifdef AUDIO_TICK_COUNT_EN
    ,
    .IO_tick_count  (tick_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc = cyc + 1;
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  // Tick at cycle t; the next tick (or reset) is at cycle n. Channel strobes
  // follow every SLOT_CYCLES until NUM_CHAN are issued or the next tick restarts.
  task automatic push_tick(input int t, input int n);
    strb_t e;
    exp_ticks.push_back(t);
    for (int k = 0; k < NUM_CHAN; k++) begin
      if (t + k * SLOT_CYCLES < n) begin
        e.c   = t + k * SLOT_CYCLES;
        e.idx = k;
        exp_strbs.push_back(e);
      end
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tick",    tick,      0);
    chk("rst_strobe",  strobe,    0);
    chk("rst_idx",     idx,       0);
    chk("rst_overrun", overrun,   0);
    chk("rst_ready",   cfg_ready, 1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT produces a tick or strobe.
  always @(negedge clk) begin
    strb_t e;
    if (mon_en) begin
      while (exp_ticks.size() > 0 && exp_ticks[0] < cyc) begin
        chk("tick_missing", cyc, exp_ticks[0]);
        void'(exp_ticks.pop_front());
      end
      while (exp_strbs.size() > 0 && exp_strbs[0].c < cyc) begin
        chk("strobe_missing", cyc, exp_strbs[0].c);
        void'(exp_strbs.pop_front());
      end
      if (tick) begin
        if (exp_ticks.size() == 0) chk("tick_extra", tick, 0);
        else                       chk("tick_cyc", cyc, exp_ticks.pop_front());
`ifdef AUDIO_TICK_COUNT_EN
        exp_cnt++;
        chk("tick_count", tick_count, exp_cnt);
`endif
      end
      if (strobe) begin
        if (exp_strbs.size() == 0) begin
          chk("strobe_extra", strobe, 0);
        end else begin
          e = exp_strbs.pop_front();
          chk("strobe_cyc", cyc, e.c);
          chk("strobe_idx", idx, e.idx);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation stuck at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int n;
    rst_n = 1'b0; en = 1'b1; cfg_valid = 1'b0; cfg_int = '0; cfg_frac = '0; ovr_clr = 1'b0;
    mon_en = 1'b0; cyc = 0; n_tests = 0; n_fail = 0; exp_cnt = 0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();

    // Release: this edge still samples reset low and counts as cycle 0.
    @(posedge clk);
    #1;
    rst_n = 1'b1; cyc = 0; mon_en = 1'b1;

    // Default divisor 9: ticks every 10 cycles.
    push_tick(10, 20); push_tick(20, 30); push_tick(30, 40);
    run_to(35);
    chk("rdy_idle", cfg_ready, 1);

    // Offer int=4 on the boundary cycle of the tick at 40: periods 10, 10, then 5.
    push_tick(40, 50); push_tick(50, 55); push_tick(55, 60); push_tick(60, 65);
    run_to(39);
    chk("rdy_pre", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_int = 12'd4; cfg_frac = 8'd0;
    step();
    cfg_valid = 1'b0;
    chk("rdy_accept1", cfg_ready, 0);
    run_to(49);
    chk("rdy_hold", cfg_ready, 0);
    step();
    chk("rdy_back", cfg_ready, 1);

    // 5-cycle periods are shorter than the 8-cycle slot sequence.
    run_to(54);
    chk("ovr_pre", overrun, 0);
    step();
    chk("ovr_set", overrun, 1);
    run_to(59);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    run_to(61);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // Fractional divisor 9 + 128/256 offered at 62, applied at the tick at 65.
    push_tick(65, 75);
    t = 75;
    for (int i = 0; i < 100; i++) begin
      n = t + (((i % 2) == 0) ? 10 : 11);
      push_tick(t, n);
      t = n;
    end
    cfg_valid = 1'b1; cfg_int = 12'd9; cfg_frac = 8'd128;
    step();
    cfg_valid = 1'b0;
    chk("rdy_frac", cfg_ready, 0);
    run_to(65);
    chk("ovr_again", overrun, 1);
    run_to(80);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("ovr_clr2", overrun, 0);

    // After 100 fractional ticks the last one lands at 1114; switch to int=19.
    run_to(1115);
    chk("rdy_slow", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_int = 12'd19; cfg_frac = 8'd0;
    step();
    cfg_valid = 1'b0;
    push_tick(t, 1145);
    push_tick(1145, 1172);
    push_tick(1172, 1192);
    push_tick(1192, 1212);
    push_tick(1212, 1216);

    // Hold the divider at count 5 of the period starting at 1145 for 7 cycles.
    run_to(1150);
    en = 1'b0;
    run_to(1157);
    en = 1'b1;
    run_to(1212);
    chk("ovr_quiet", overrun, 0);

    // Pending config then reset in the middle of a slot sequence.
    run_to(1213);
    cfg_valid = 1'b1; cfg_int = 12'd4; cfg_frac = 8'd0;
    step();
    cfg_valid = 1'b0;
    chk("rdy_pend", cfg_ready, 0);
    run_to(1215);
    rst_n = 1'b0;
    step();
    chk_reset_outputs();
    chk("ticks_left", exp_ticks.size(), 0);
    chk("strobes_left", exp_strbs.size(), 0);

    // Reset edge at the start of this cycle becomes the new cycle 0; the
    // discarded int=4 divisor must not show up.
    rst_n = 1'b1; cyc = 0; exp_cnt = 0;
    push_tick(10, 20); push_tick(20, 30); push_tick(30, 40);
    run_to(37);
    chk("ovr_end", overrun, 0);
    chk("ticks_left_end", exp_ticks.size(), 0);
    chk("strobes_left_end", exp_strbs.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
